// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared constants and types for the UART command TX/RX pair.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'h21;
    localparam logic [7:0] ID_MGU      = 8'h4D;
    localparam logic [7:0] ID_GNU      = 8'h47;
    localparam int         FRAME_BYTES = 4;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_SEND = 2'd1,
        FR_DONE = 2'd2
    } frame_state_t;

    // Payload bytes travel as printable characters; the add wraps at 8 bits.
    function automatic logic [7:0] ascii_encode(input logic [7:0] i_b, input logic [7:0] i_off);
        return i_b + i_off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer; accepts a new byte in its last stop cycle
//               so consecutive bytes leave with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_dv,
    input  logic [7:0] i_byte,
    output logic       o_tx_serial,
    output logic       o_active,
    output logic       o_done
);

    localparam int              c_cw       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [1:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            w_bit_end;

    assign w_bit_end   = (r_cnt == c_cnt_last);
    assign o_tx_serial = r_tx;
    assign o_active    = (r_state != c_st_idle);
    assign o_done      = (r_state == c_st_stop) && w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (i_tx_dv) begin
                        r_shift <= i_byte;
                        r_tx    <= 1'b0;
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= c_st_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (i_tx_dv) begin
                            r_shift <= i_byte;
                            r_tx    <= 1'b0;
                            r_state <= c_st_start;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_tx
// Description : Command-frame UART transmitter: sync, ID, two offset payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] ASCII_OFFSET = 8'h30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_id,
    input  logic [15:0] cmd_data,
    output logic        tx_serial,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] c_last_idx = 2'(FRAME_BYTES - 1);

    frame_state_t r_state;
    logic [1:0]   r_idx;
    logic [7:0]   r_id;
    logic [15:0]  r_data;

    logic         w_accept;
    logic         w_tx_dv;
    logic [1:0]   w_next_idx;
    logic [7:0]   w_byte;
    logic         w_ser_active;
    logic         w_ser_done;

    assign cmd_ready  = (r_state == FR_IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign busy       = (r_state != FR_IDLE) || w_ser_active;
    assign frame_done = (r_state == FR_DONE);

    // The first byte is a constant, so it can be launched in the acceptance
    // cycle itself before the command registers are loaded.
    assign w_tx_dv    = w_accept || ((r_state == FR_SEND) && w_ser_done && (r_idx != c_last_idx));
    assign w_next_idx = w_accept ? 2'd0 : r_idx + 2'd1;

    always_comb begin
        w_byte = SYNC_BYTE;
        case (w_next_idx)
            2'd1:    w_byte = r_id;
            2'd2:    w_byte = ascii_encode(r_data[15:8], ASCII_OFFSET);
            2'd3:    w_byte = ascii_encode(r_data[7:0], ASCII_OFFSET);
            default: w_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FR_IDLE;
            r_idx   <= 2'd0;
            r_id    <= 8'd0;
            r_data  <= 16'd0;
        end else begin
            case (r_state)
                FR_IDLE: begin
                    if (w_accept) begin
                        r_id    <= cmd_id;
                        r_data  <= cmd_data;
                        r_idx   <= 2'd0;
                        r_state <= FR_SEND;
                    end
                end
                FR_SEND: begin
                    if (w_ser_done) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= FR_DONE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end
                default: r_state <= FR_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk         (clk),
        .rst         (rst),
        .i_tx_dv     (w_tx_dv),
        .i_byte      (w_byte),
        .o_tx_serial (tx_serial),
        .o_active    (w_ser_active),
        .o_done      (w_ser_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_tx
// Description : Directed self-checking bench for uart_cmd_tx with a mid-bit monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_tx;
    import uart_cmd_pkg::*;

    localparam int CPB = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_id    = 8'd0;
    logic [15:0] cmd_data  = 16'd0;
    logic        cmd_ready;
    logic        tx_serial;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_cmd_tx #(
        .CLKS_PER_BIT (CPB),
        .ASCII_OFFSET (8'h30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_data   (cmd_data),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that opens the acceptance cycle, with cmd_valid
    // already high. Returns #1 after the edge where cmd_ready comes back.
    task automatic run_frame(input logic [31:0] exp_bytes, input bit hold,
                             input logic [7:0] nid, input logic [15:0] ndata);
        logic       s [0:159];
        logic [7:0] b;
        bit         early;
        bit         ferr;
        check_eq("ready_before_accept", cmd_ready, 1);
        step();
        check_eq("start_bit_t0", tx_serial, 0);
        check_eq("busy_rise", busy, 1);
        check_eq("ready_fall", cmd_ready, 0);
        if (hold) begin
            cmd_id   = nid;
            cmd_data = ndata;
        end else begin
            cmd_valid = 1'b0;
        end
        s[0]  = tx_serial;
        early = frame_done;
        for (int t = 1; t < 160; t++) begin
            step();
            s[t] = tx_serial;
            if (frame_done || cmd_ready || !busy) early = 1'b1;
        end
        check_eq("no_early_done_or_ready", early, 0);
        step();
        check_eq("frame_done_pulse", frame_done, 1);
        check_eq("busy_in_done", busy, 1);
        check_eq("tx_idle_after_stop", tx_serial, 1);
        ferr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (s[(10*k)*CPB + 2] !== 1'b0 || s[(10*k + 9)*CPB + 2] !== 1'b1) ferr = 1'b1;
            for (int j = 0; j < 8; j++) b[j] = s[(10*k + 1 + j)*CPB + 2];
            check_eq($sformatf("byte%0d", k), b, exp_bytes[31 - 8*k -: 8]);
        end
        check_eq("framing_start_stop", ferr, 0);
        step();
        check_eq("ready_return", cmd_ready, 1);
        check_eq("done_single_cycle", frame_done, 0);
        check_eq("busy_fall", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_tx", tx_serial, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", frame_done, 0);
            check_eq("rst_ready", cmd_ready, 0);
        end
        rst = 1'b0;
        #1;
        check_eq("ready_after_release", cmd_ready, 1);
        step();
        check_eq("idle_tx", tx_serial, 1);
        check_eq("idle_ready", cmd_ready, 1);

        // Normal frame
        cmd_valid = 1'b1; cmd_id = ID_MGU; cmd_data = 16'h0102;
        run_frame(32'h214D3132, 1'b0, 8'h00, 16'h0000);
        step();
        step();

        // Offset wrap
        cmd_valid = 1'b1; cmd_id = ID_GNU; cmd_data = 16'hFFD0;
        run_frame(32'h21472F00, 1'b0, 8'h00, 16'h0000);
        step();

        // Second command held through the first frame, then taken on the ready cycle
        cmd_valid = 1'b1; cmd_id = ID_MGU; cmd_data = 16'h1234;
        run_frame(32'h214D4264, 1'b1, ID_GNU, 16'h0509);
        run_frame(32'h21473539, 1'b0, 8'h00, 16'h0000);
        step();

        // Reset during byte 2 data bits (byte2 = 0xDB, bit 2 is a zero)
        cmd_valid = 1'b1; cmd_id = ID_MGU; cmd_data = 16'hABCD;
        step();
        cmd_valid = 1'b0;
        for (int t = 1; t <= 92; t++) step();
        check_eq("pre_reset_bit", tx_serial, 0);
        rst = 1'b1;
        step();
        check_eq("rst_mid_tx", tx_serial, 1);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", frame_done, 0);
        step();
        check_eq("rst_mid_done2", frame_done, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_ready", cmd_ready, 1);
        step();
        check_eq("rst_mid_idle_tx", tx_serial, 1);

        cmd_valid = 1'b1; cmd_id = ID_GNU; cmd_data = 16'h0000;
        run_frame(32'h21473030, 1'b0, 8'h00, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
